// File: rtl/complex_mag_stream_sqrt_iter.sv
// Bit-serial restoring integer square root on a valid/ready stream.
// Produces floor(sqrt(x)) and x - root^2, one root bit per enabled clock.
module complex_mag_stream_sqrt_iter #(
  parameter int DIN_WIDTH  = 36,
  parameter int DOUT_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DIN_WIDTH-1:0]  s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DOUT_WIDTH-1:0] m_tdata,
  output logic [DOUT_WIDTH:0]   m_trem,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int RW = DOUT_WIDTH + 2;
  localparam int CW = (DOUT_WIDTH > 1) ? $clog2(DOUT_WIDTH) : 1;

  generate
    if (DOUT_WIDTH * 2 != DIN_WIDTH) begin : g_bad_width
      $error("DOUT_WIDTH must equal DIN_WIDTH/2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIN_WIDTH-1:0]  x_q, x_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [DOUT_WIDTH-1:0] root_q, root_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic [DOUT_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [DOUT_WIDTH:0]   m_trem_q, m_trem_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;

  logic          accept;
  logic [RW-1:0] rem_sh;
  logic [RW-1:0] trial;

  assign s_tready = ce & ~reset & ((state_q == IDLE) | ((state_q == DONE) & m_tready));
  assign accept   = s_tvalid & s_tready;

  // Next digit: bring down two bits of x, try subtracting 4*root+1.
  assign rem_sh = {rem_q[RW-3:0], x_q[DIN_WIDTH-1 -: 2]};
  assign trial  = {root_q, 2'b01};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    rem_d      = rem_q;
    root_d     = root_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    m_tdata_d  = m_tdata_q;
    m_trem_d   = m_trem_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;

    case (state_q)
      CALC: begin
        if (ce) begin
          x_d   = x_q << 2;
          cnt_d = cnt_q - 1'b1;
          if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = {root_q[DOUT_WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = rem_sh;
            root_d = {root_q[DOUT_WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            m_tdata_d  = root_d;
            m_trem_d   = rem_d[DOUT_WIDTH:0];
            m_tlast_d  = last_q;
            m_tvalid_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (ce & m_tready) begin
          m_tvalid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or the output-transfer edge of DONE,
    // so it can safely override the state decision above.
    if (accept) begin
      x_d     = s_tdata;
      rem_d   = '0;
      root_d  = '0;
      last_d  = s_tlast;
      cnt_d   = CW'(DOUT_WIDTH - 1);
      state_d = CALC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      m_tdata_q  <= '0;
      m_trem_q   <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      m_tdata_q  <= m_tdata_d;
      m_trem_q   <= m_trem_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_trem   = m_trem_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;

endmodule

// File: doc/complex_mag_stream_sqrt_iter.md
Name: complex_mag_stream_sqrt_iter

Overview:
Iterative integer square-root stage directly downstream of the complex-magnitude squaring/accumulate datapath. It consumes the unsigned magnitude-squared word re^2+im^2 and produces floor(sqrt(x)) plus the remainder on a valid/ready stream. It computes one result bit per clock, so the area is small and throughput is one sample per DOUT_WIDTH+1 cycles.

Parameters:
DIN_WIDTH, 36, width of the unsigned magnitude-squared input; must be even.
DOUT_WIDTH, 18, root width; must equal DIN_WIDTH/2 (elaboration error otherwise).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high; overrides ce
ce  in  1  clock enable; when 0 all state frozen and no transfer occurs
s_tdata  in  DIN_WIDTH  unsigned x = re^2+im^2
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tlast  in  1  end-of-frame marker, travels with the sample
m_tdata  out  DOUT_WIDTH  floor(sqrt(x))
m_trem  out  DOUT_WIDTH+1  x - m_tdata^2 (range 0..2*m_tdata)
m_tvalid  out  1  output valid
m_tready  in  1  output ready
m_tlast  out  1  copy of the captured s_tlast

Behaviour:
- Reset (reset=1 at an edge): state=IDLE, m_tvalid=0, m_tdata=0, m_trem=0, m_tlast=0, iteration counter=0, working registers=0. s_tready=0 while reset is high.
- s_tready = ce & ~reset & (state==IDLE | (state==DONE & m_tready)). Combinational from state and m_tready.
- Input transfer: on an edge with s_tvalid & s_tready. Capture x into a shift register, clear rem/root, capture tlast, load counter=DOUT_WIDTH-1, go to CALC.
- CALC runs one restoring digit step per ce-enabled edge:
  - rem' = (rem<<2) | top two bits of x; x <<= 2.
  - trial = (root<<2)|1.
  - If rem' >= trial: rem = rem' - trial and root = (root<<1)|1. Otherwise rem = rem' and root = root<<1.
  - Working rem width is DOUT_WIDTH+2 bits; no overflow is possible.
  - Counter decrements each step. On the step taken with counter==0, register root into m_tdata and rem into m_trem, set m_tvalid=1, and go to DONE.
- Latency: m_tvalid rises after exactly DOUT_WIDTH ce-enabled edges following the accept edge (18 by default).
- DONE: m_tdata, m_trem, m_tlast and m_tvalid are held stable until an edge with m_tvalid & m_tready.
  - On that edge, if s_tvalid is also 1 (s_tready is 1), the next sample is captured the same edge and the state goes directly to CALC. m_tvalid drops the next cycle.
  - Otherwise the state goes to IDLE and m_tvalid drops.
  - Sustained throughput is 1 sample per DOUT_WIDTH+1 cycles.
- m_tvalid never deasserts without a completed output transfer, except on reset.
- ce=0: no register changes, s_tready=0, outputs hold. A m_tready pulse during ce=0 is not a transfer.
- Reset during CALC or DONE discards the in-flight sample. The first s_tready=1 is in the cycle after reset deasserts.
- s_tvalid while busy (CALC) is ignored and the upstream must hold the sample. s_tdata is sampled only on the accept edge.
- Stage state is limited to the working registers and the output regs; it holds only one sample in flight.

Test Plan:
- Reset then x=0, tlast=1 -> after 18 edges m_tdata=0, m_trem=0, m_tlast=1.
- x=2^36-1 -> m_tdata=262143, m_trem=524286. Also x=1000000 -> 1000, rem 0. Also x=999999 -> 999, rem 1998.
- Back-to-back x=16, x=17 with m_tvalid/s_tvalid/m_tready held 1 -> results 4/0 then 4/1. The second sample is accepted on the edge the first result transfers. m_tvalid rising edges are 19 cycles apart.
- Backpressure: hold m_tready=0 for 5 cycles in DONE -> m_tdata/m_trem/m_tvalid stable and s_tready=0. Release -> single transfer, then state IDLE.
- Reset asserted mid-CALC (iteration 7) -> next cycle m_tvalid=0, outputs 0, no result emitted. A new x=81 after reset -> 9, rem 0.
- ce toggled 0 on every other cycle during CALC for x=50 -> result 7, rem 1 after 18 enabled edges. No transfer is counted while ce=0.
- Random: 10k random 36-bit x vs a golden isqrt model -> all m_tdata and m_trem match, with m_tdata^2+m_trem==x and m_trem<=2*m_tdata.
